// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-operand MEM/WB bypass selects plus load-use / RAW stall control.
// Define FWD_STALL_CNT_EN to build the saturating stall-cycle counter behind stall_cnt.
module fwd_hazard_unit #(
  parameter int ADDR_W   = 4,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [ADDR_W-1:0]         exe_dest,
  input  logic                      exe_wb_en,
  input  logic                      exe_mem_read,
  input  logic [ADDR_W-1:0]         mem_dest,
  input  logic                      mem_wb_en,
  input  logic [ADDR_W-1:0]         wb_dest,
  input  logic                      wb_wb_en,
  input  logic                      fwd_en,
  input  logic                      freeze,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      sel_src,
  output logic                      hazard_stall,
  output logic [31:0]               stall_cnt
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {IDLE, LWAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ld_m, m_exe, m_mem, m_wb;
  logic               load_hz, raw_hz, detect;
  logic               stall_d;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ld_m[i]  = src_valid[i] &
                 (exe_dest == src[i*ADDR_W +: ADDR_W]);
      m_exe[i] = ld_m[i] & exe_wb_en;
      m_mem[i] = src_valid[i] & mem_wb_en &
                 (mem_dest == src[i*ADDR_W +: ADDR_W]);
      m_wb[i]  = src_valid[i] & wb_wb_en &
                 (wb_dest == src[i*ADDR_W +: ADDR_W]);
    end
  end

  assign load_hz = exe_wb_en & exe_mem_read & (|ld_m);
  // WB is left out: the register file writes it in the first half-cycle.
  assign raw_hz  = |(m_exe | m_mem);
  assign detect  = fwd_en ? load_hz : raw_hz;

  // MEM beats WB since it carries the younger result.
  always_comb begin
    sel_src = '0;
    if (fwd_en && !rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_mem[i])
          sel_src[i*2 +: 2] = 2'b01;
        else if (m_wb[i])
          sel_src[i*2 +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_d = detect;
          if (fwd_en && load_hz && !freeze &&
              (LOAD_LAT > 1)) begin
            state_d = LWAIT;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
          end
        end
        LWAIT: begin
          stall_d = 1'b1;
          if (!freeze) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign hazard_stall = stall_d & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall && !freeze &&
        (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage ARM pipeline. It sits between ID/EXE and the register-file read path.
- Generates per-source bypass selects from the MEM and WB stages.
- Detects load-use hazards and holds the front end for a configurable number of load-latency bubbles using a small stall FSM.
- Supports a no-forwarding mode in which every RAW hazard is resolved by stalling.

Parameters:
- ADDR_W, 4, register address width.
- NUM_SRC, 3, number of source operands checked (Rn, Rm, Rd-for-store).
- LOAD_LAT, 1, total bubble cycles per load-use hazard; legal range 1..8.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- src  input  NUM_SRC*ADDR_W  ID-stage source addresses; operand i occupies bits [i*ADDR_W +: ADDR_W].
- src_valid  input  NUM_SRC  operand i is actually read.
- exe_dest  input  ADDR_W  EXE-stage destination.
- exe_wb_en  input  1  EXE instruction writes back.
- exe_mem_read  input  1  EXE instruction is a load.
- mem_dest  input  ADDR_W  MEM-stage destination.
- mem_wb_en  input  1  MEM instruction writes back.
- wb_dest  input  ADDR_W  WB-stage destination.
- wb_wb_en  input  1  WB instruction writes back.
- fwd_en  input  1  1 = forwarding mode; 0 = stall-only mode.
- freeze  input  1  whole pipeline frozen (memory wait); FSM holds.
- flush  input  1  branch taken; ID instruction discarded.
- sel_src  output  NUM_SRC*2  per-operand select: 00 register file, 01 MEM, 10 WB.
- hazard_stall  output  1  freeze PC and IF/ID, insert bubble into EXE.
- stall_cnt  output  32  stall-cycle performance counter (feature-gated).

Behaviour:
- Reset: while rst=1, sel_src=0, hazard_stall=0, state=IDLE, bubble counter=0, stall_cnt=0.
- Match definition: m(stage,i) = src_valid[i] & stage_wb_en & (stage_dest == src[i]).
- Forwarding (fwd_en=1):
  - sel_src[i] = 01 if m(MEM,i); else 10 if m(WB,i); else 00.
  - MEM has priority over WB because it holds the newer value.
  - Purely combinational; zero latency.
- fwd_en=0: sel_src is always 00.
- Hazard detection, combinational:
  - load_hz = exe_wb_en & exe_mem_read & any_i(src_valid[i] & exe_dest==src[i]).
  - With fwd_en=0, raw_hz = any_i(m(EXE,i) | m(MEM,i)), where m(EXE,i) is the EXE-stage match built from exe_dest and exe_wb_en. WB is excluded because the register file writes in the first half-cycle.
  - detect = fwd_en ? load_hz : raw_hz.
- FSM states: IDLE, LWAIT. Bubble counter width is $clog2(LOAD_LAT+1).
  - IDLE: hazard_stall = detect & ~flush.
  - IDLE -> LWAIT when fwd_en & load_hz & ~flush & ~freeze & LOAD_LAT>1; counter loads LOAD_LAT-1.
  - With LOAD_LAT=1, LWAIT is never entered; only the detect cycle stalls.
  - LWAIT: hazard_stall=1. Each non-frozen cycle the counter decrements.
  - LWAIT -> IDLE when the counter reaches 1 on a non-frozen cycle; the stall drops in the following cycle.
- freeze=1: state and counter hold; hazard_stall is still driven per the current state.
- flush=1:
  - In any state, the next state is IDLE and the counter clears.
  - hazard_stall=0 in the same cycle; flush wins over a simultaneous detect.
- Reset mid-LWAIT: IDLE on the next edge; no residual stall.
- Stall-only mode never enters LWAIT. The stall persists each cycle while raw_hz holds and naturally clears as the producer drains.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every clk edge where hazard_stall=1, rst=0 and freeze=0.
  - It saturates at 32'hFFFF_FFFF and clears on rst.
- Undefined: stall_cnt is tied to 0 and no counter flops are generated.

Test Plan:
- fwd_en=1, src[0]=3, valid, mem_dest=3/mem_wb_en=1, wb_dest=3/wb_wb_en=1 -> sel_src[1:0]=01 (MEM priority). Then mem_wb_en=0 -> 10. Then src_valid[0]=0 -> 00.
- LOAD_LAT=3, exe_dest=5 with exe_mem_read=1/exe_wb_en=1, src[1]=5, one cycle -> hazard_stall high for exactly 3 consecutive cycles, then low; with FWD_STALL_CNT_EN, stall_cnt=3.
- LOAD_LAT=3 hazard, freeze=1 for 2 cycles during LWAIT -> hazard_stall high for 5 cycles total, and stall_cnt increments only on the 3 non-frozen cycles.
- LOAD_LAT=4 hazard, flush=1 on the 2nd stall cycle -> hazard_stall=0 that cycle, state=IDLE on the next edge. Repeat with rst=1 instead of flush -> all outputs 0 on the next cycle.
- fwd_en=0, src[0]=7, exe_dest=7/exe_wb_en=1 (not a load) -> hazard_stall=1 and sel_src=00. Then only wb_dest=7/wb_wb_en=1 -> hazard_stall=0.
- NUM_SRC=3: src[2]=9 is a store data register, exe load to 9 -> stall; exe_dest=9 with exe_mem_read=0 -> no stall.
